// File: rtl/wb_b3_pkg.sv
// ---------------------------------------------------------------------------
// wb_b3_pkg
// Shared definitions for the Wishbone B3 burst master:
//   - CTI cycle-type codes (classic, constant, incrementing, end-of-burst)
//   - BTE burst-type codes (linear, wrap-4, wrap-8, wrap-16)
//   - FSM state encoding (IDLE, BURST, GAP)
//   - helpers for burst length and wrap-window mask
// ---------------------------------------------------------------------------
package wb_b3_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Number of beats in a burst. Linear bursts use the configured length.
    function automatic logic [4:0] beat_count(input logic       single,
                                              input logic [1:0] bte,
                                              input logic [4:0] lin);
        logic [4:0] n;
        n = lin;
        if (single) begin
            n = 5'd1;
        end else begin
            case (bte)
                BTE_WRAP4:  n = 5'd4;
                BTE_WRAP8:  n = 5'd8;
                BTE_WRAP16: n = 5'd16;
                default:    n = lin;
            endcase
        end
        return n;
    endfunction

    // Word-address bits that wrap inside the burst window (0 for linear).
    function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
        logic [3:0] m;
        case (bte)
            BTE_WRAP4:  m = 4'h3;
            BTE_WRAP8:  m = 4'h7;
            BTE_WRAP16: m = 4'hF;
            default:    m = 4'h0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/wb_b3_burst_master_if.sv
// ---------------------------------------------------------------------------
// wb_b3_burst_master_if
// Wishbone B3 master-side bus bundle.
//   master modport: drives adr/dat_o/sel/we/cyc/stb/cti/bte,
//                   receives dat_i/ack/err/rty
//   slave modport : the mirror image
// Parameters: aw (byte-address width), dw (data width, 32 only).
// ---------------------------------------------------------------------------
interface wb_b3_burst_master_if #(
    parameter int aw = 25,
    parameter int dw = 32
);
    logic [aw-1:0]   wbm_adr_o;
    logic [dw-1:0]   wbm_dat_o;
    logic [dw/8-1:0] wbm_sel_o;
    logic            wbm_we_o;
    logic            wbm_cyc_o;
    logic            wbm_stb_o;
    logic [2:0]      wbm_cti_o;
    logic [1:0]      wbm_bte_o;
    logic [dw-1:0]   wbm_dat_i;
    logic            wbm_ack_i;
    logic            wbm_err_i;
    logic            wbm_rty_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o,
               wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o,
               wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );
endinterface

// File: rtl/wb_b3_rdfifo.sv
// ---------------------------------------------------------------------------
// wb_b3_rdfifo
// Two-entry read-data FIFO between the Wishbone bus and the read stream.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties FIFO)
//   i_push, i_din   write side (ignored when full)
//   i_pop           read side (ignored when empty)
//   o_dout          head entry
//   o_full, o_empty occupancy flags
// ---------------------------------------------------------------------------
module wb_b3_rdfifo #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [width-1:0] i_din,
    input  logic             i_pop,
    output logic [width-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    logic [width-1:0] r_mem [0:1];
    logic             r_wp;
    logic             r_rp;
    logic [1:0]       r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_cnt == 2'd2);
    assign o_empty = (r_cnt == 2'd0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_dout  = r_mem[r_rp];

    // Storage carries no reset; only pointers and count are control.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_wp <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: rtl/wb_b3_burst_master.sv
// ---------------------------------------------------------------------------
// wb_b3_burst_master
// Wishbone B3 registered-feedback burst master. Accepts one burst request
// at a time and runs it as linear, wrap-4/8/16 or single classic cycle.
//
// Parameters: aw (byte-address width), dw (data width, 32 only),
//             lin_beats (beats in a linear burst, 2..16)
// Ports:
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   req_*                         burst request (valid/ready)
//   wr_dat_i/wr_sel_i/wr_valid_i/wr_ready_o   write-data stream
//   rd_dat_o/rd_valid_o/rd_ready_i            read-data stream
//   done_o, err_o                 end-of-burst pulse and status
//   wbm                           Wishbone master bus (interface)
//
// Optional feature macro: WB_BURST_MASTER_ERR_EN
//   defined   -> wbm_err_i terminates the burst with done_o/err_o high
//   undefined -> wbm_err_i ignored, err_o tied low
// ---------------------------------------------------------------------------
module wb_b3_burst_master
    import wb_b3_pkg::*;
#(
    parameter int aw        = 25,
    parameter int dw        = 32,
    parameter int lin_beats = 4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,

    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [aw-1:0]   req_adr_i,
    input  logic            req_we_i,
    input  logic [1:0]      req_bte_i,
    input  logic            req_single_i,

    input  logic [dw-1:0]   wr_dat_i,
    input  logic [dw/8-1:0] wr_sel_i,
    input  logic            wr_valid_i,
    output logic            wr_ready_o,

    output logic [dw-1:0]   rd_dat_o,
    output logic            rd_valid_o,
    input  logic            rd_ready_i,

    output logic            done_o,
    output logic            err_o,

    wb_b3_burst_master_if.master wbm
);
    localparam int         WA        = aw - 2;
    localparam logic [4:0] LIN_BEATS = 5'(lin_beats);

    state_t          r_state;
    state_t          w_state_nxt;

    logic [WA-1:0]   r_wadr;
    logic            r_we;
    logic [1:0]      r_bte;
    logic            r_single;
    logic [4:0]      r_beats;
    logic            r_done;
    logic            r_err;

    logic            w_in_burst;
    logic            w_last;
    logic            w_stb;
    logic            w_adv;
    logic            w_err;
    logic            w_load;
    logic            w_finish;
    logic [WA-1:0]   w_adr_inc;
    logic [WA-1:0]   w_mask;
    logic [WA-1:0]   w_adr_nxt;

    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic            w_fifo_push;
    logic            w_fifo_pop;

    assign w_in_burst = (r_state == ST_BURST);
    assign w_last     = (r_beats == 5'd1);

    // Writes strobe only while source data is present; reads strobe only
    // while the FIFO has room, so every ack always has a place to land.
    assign w_stb = w_in_burst & (r_we ? wr_valid_i : ~w_fifo_full);

`ifdef WB_BURST_MASTER_ERR_EN
    assign w_err = w_stb & wbm.wbm_err_i;
`else
    assign w_err = 1'b0;
`endif

    // Retry is a wait state: the beat is re-presented, nothing advances.
    assign w_adv = w_stb & wbm.wbm_ack_i & ~wbm.wbm_rty_i & ~w_err;

    // Linear bursts step the whole word address; wrap bursts only the
    // low bits inside the window, leaving the upper bits untouched.
    assign w_adr_inc = r_wadr + WA'(1);
    assign w_mask    = WA'(wrap_mask(r_bte));
    assign w_adr_nxt = (r_bte == BTE_LINEAR) ? w_adr_inc
                     : ((r_wadr & ~w_mask) | (w_adr_inc & w_mask));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = 1'b0;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_err || (w_adv && w_last)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            // One dead cycle so the slave's combinational ack falls
            // before the next burst starts.
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wadr   <= '0;
            r_we     <= 1'b0;
            r_bte    <= BTE_LINEAR;
            r_single <= 1'b0;
            r_beats  <= 5'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= w_finish;
            r_err  <= w_finish & w_err;
            if (w_load) begin
                r_wadr   <= req_adr_i[aw-1:2];
                r_we     <= req_we_i;
                r_bte    <= req_bte_i;
                r_single <= req_single_i;
                r_beats  <= beat_count(req_single_i, req_bte_i, LIN_BEATS);
            end else if (w_adv) begin
                r_wadr  <= w_adr_nxt;
                r_beats <= r_beats - 5'd1;
            end
        end
    end

    assign w_fifo_push = w_adv & ~r_we;
    assign w_fifo_pop  = rd_valid_o & rd_ready_i;

    wb_b3_rdfifo #(
        .width (dw)
    ) u_rdfifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .i_push  (w_fifo_push),
        .i_din   (wbm.wbm_dat_i),
        .i_pop   (w_fifo_pop),
        .o_dout  (rd_dat_o),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign rd_valid_o = ~w_fifo_empty;
    assign wr_ready_o = w_adv & r_we;
    assign done_o     = r_done;
`ifdef WB_BURST_MASTER_ERR_EN
    assign err_o      = r_err;
`else
    assign err_o      = 1'b0;
`endif

    assign wbm.wbm_cyc_o = w_in_burst;
    assign wbm.wbm_stb_o = w_stb;
    assign wbm.wbm_we_o  = w_in_burst & r_we;
    assign wbm.wbm_adr_o = {r_wadr, 2'b00};
    assign wbm.wbm_bte_o = r_bte;
    assign wbm.wbm_dat_o = wr_dat_i;
    assign wbm.wbm_sel_o = wr_sel_i;

    always_comb begin
        wbm.wbm_cti_o = CTI_CLASSIC;
        if (w_in_burst && !r_single) begin
            wbm.wbm_cti_o = w_last ? CTI_EOB : CTI_INCR;
        end
    end
endmodule

// File: doc/wb_b3_burst_master.md
WB_B3_BURST_MASTER -- requirements
Module: wb_b3_burst_master

Interface
REQ-001 SHALL have parameter aw, default 25, Wishbone byte-address width.
REQ-002 SHALL have parameter dw, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter lin_beats, default 4, beat count for linear (bte=00) bursts; range 2..16.
REQ-004 SHALL have port wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid_i  in  1  burst request present.
REQ-007 SHALL have port req_ready_o  out  1  request accepted when high with req_valid_i.
REQ-008 SHALL have ports req_adr_i  in  aw  start byte address, req_we_i  in  1  write burst, req_bte_i  in  2  burst type (00 linear, 01/10/11 wrap 4/8/16), req_single_i  in  1  single classic beat.
REQ-009 SHALL have ports wr_dat_i  in  32, wr_sel_i  in  4, wr_valid_i  in  1, wr_ready_o  out  1  write-data stream.
REQ-010 SHALL have ports rd_dat_o  out  32, rd_valid_o  out  1, rd_ready_i  in  1  read-data stream.
REQ-011 SHALL have ports done_o  out  1  one-cycle pulse at burst end; err_o  out  1  valid with done_o.
REQ-012 SHALL have Wishbone master ports wbm_adr_o[aw], wbm_dat_o[32], wbm_sel_o[4], wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o[3], wbm_bte_o[2] (out); wbm_dat_i[32], wbm_ack_i, wbm_err_i, wbm_rty_i (in).

Function
REQ-013 SHALL implement FSM states IDLE, BURST, GAP.
REQ-014 IDLE: req_ready_o=1; on req_valid_i latch adr/we/bte/single, set beat counter, go BURST next cycle.
REQ-015 BURST: wbm_cyc_o=1; wbm_adr_o[1:0]=0; wbm_we_o, wbm_bte_o held from latched request.
REQ-016 Beat count: single=1; else bte 01/10/11 -> 4/8/16; bte 00 -> lin_beats.
REQ-017 wbm_cti_o SHALL be 000 for single, 010 for all non-final beats, 111 on final beat.
REQ-018 Next word address after each ack: linear = adr[aw-1:2]+1 (wraps modulo 2^(aw-2)); wrap-N = low log2(N) word bits incremented modulo N, upper bits unchanged.
REQ-019 Write burst: wbm_stb_o = wr_valid_i; wbm_dat_o/wbm_sel_o = wr_dat_i/wr_sel_i; wr_ready_o = wbm_ack_i in BURST, else 0.
REQ-020 Read burst: 2-entry read FIFO; wbm_stb_o = FIFO not full; on wbm_ack_i push wbm_dat_i; rd_valid_o = FIFO not empty; pop on rd_valid_o & rd_ready_i; simultaneous push+pop on full-minus-one keeps count.
REQ-021 wbm_ack_i SHALL be accepted in the same cycle as wbm_stb_o (combinational slave ack); ack with stb low SHALL be ignored.
REQ-022 On ack of final beat: BURST -> GAP; done_o=1, err_o=0 that cycle.
REQ-023 GAP: cyc/stb low exactly one cycle, req_ready_o=0, then IDLE (guarantees slave ack deassert between bursts).
REQ-024 wbm_rty_i SHALL be treated as a wait state (beat retried, no advance).
REQ-025 Read done_o SHALL fire on final ack even if FIFO still holds data; FIFO drains independently and is not cleared by IDLE.
REQ-026 Maximum throughput: one beat per cycle when source/sink never stall.

Reset
REQ-027 On wb_rst_i: state IDLE, FIFO empty, cyc/stb/we=0, cti=000, bte=00, adr=0, done_o=err_o=0, rd_valid_o=0, wr_ready_o=0.
REQ-028 Reset mid-burst SHALL drop cyc/stb next cycle with no done_o pulse and discard FIFO contents.

Configuration
REQ-029 Macro WB_BURST_MASTER_ERR_EN defined: wbm_err_i with stb in BURST ends burst immediately (-> GAP), done_o=1 and err_o=1, remaining write data not consumed.
REQ-030 Macro undefined: wbm_err_i ignored; err_o tied 0.

Structure
REQ-031 Shared package wb_b3_pkg SHALL hold CTI codes (CLASSIC 000, CONST 001, INCR 010, EOB 111), BTE codes and FSM state encoding.
REQ-032 Read FIFO SHALL be sub-module wb_b3_rdfifo (depth 2, width 32).

Verification
REQ-033 Linear read, adr 0x100, bte 00, lin_beats 4, rd_ready_i=1 -> adr 0x100..0x10C, cti 010,010,010,111, 4 rd_valid_o, done_o one cycle after last ack.
REQ-034 Wrap-4 read at 0x108 -> adr 0x108,0x10C,0x100,0x104; wrap-8 at 0x11C -> 0x11C,0x100..0x118.
REQ-035 Write wrap-4 with wr_valid_i low on beat 2 for 3 cycles -> stb low those cycles, 4 wr_ready_o pulses, memory contents match.
REQ-036 Read with rd_ready_i=0 -> stb drops after 2 acks, resumes on rd_ready_i, no data lost, order preserved.
REQ-037 Single write, sel 0011 -> cti 000, one beat, GAP cycle then back-to-back request accepted; with WB_BURST_MASTER_ERR_EN, err on beat 2 -> done_o=err_o=1, cyc low next cycle.
REQ-038 Assert wb_rst_i during beat 3 of 8 -> cyc low next cycle, no done_o, rd_valid_o=0.
